// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: handshake, wait states, byte/half/word access
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rsp_err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          f3_q;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                commit;
    logic                c_wr, c_rd;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic [2:0]          c_f3;
    logic [IDX_W-1:0]    c_idx;
    logic [1:0]          c_off;
    logic                f3_legal, illegal, misaligned, err;
    logic [DATA_W-1:0]   rd_word;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_val;
    logic [3:0]          st_be;
    logic [DATA_W-1:0]   st_data;

    assign accept    = (state_q == S_IDLE) && req_valid;
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rd_data   = rd_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the accept edge, so decode the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            c_wr    = wr;
            c_rd    = rd;
            c_addr  = addr;
            c_wdata = wr_data;
            c_f3    = funct3;
        end else begin
            c_wr    = wr_q;
            c_rd    = rd_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_f3    = f3_q;
        end
    end

    assign c_idx  = c_addr[ADDR_W-1:2];
    assign c_off  = c_addr[1:0];
    assign commit = reset && (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        f3_legal = 1'b0;
        case (c_f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
        illegal    = (c_wr == c_rd) || !f3_legal || (c_wr && c_f3[2]);
        misaligned = ((c_f3[1:0] == 2'b01) && c_off[0]) ||
                     ((c_f3 == 3'b010) && (c_off != 2'b00));
        err        = illegal || misaligned;
    end

    always_comb begin
        rd_word = mem_q[c_idx];
        ld_byte = rd_word[{c_off, 3'b000} +: 8];
        ld_half = c_off[1] ? rd_word[31:16] : rd_word[15:0];
        ld_val  = '0;
        case (c_f3)
            3'b000:  ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b010:  ld_val = rd_word;
            3'b100:  ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b101:  ld_val = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_val = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select the target.
    always_comb begin
        st_be   = 4'b0000;
        st_data = c_wdata;
        case (c_f3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << c_off;
                st_data = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = c_off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{c_wdata[15:0]}};
            end
            2'b10:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        rsp_err_d = err;
        rd_data_d = (err || c_wr) ? '0 : ld_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
            rd_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= wr;
                rd_q    <= rd;
                addr_q  <= addr;
                wdata_q <= wr_data;
                f3_q    <= funct3;
            end
            if (commit) begin
                rd_data_q <= rd_data_d;
                rsp_err_q <= rsp_err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[c_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule
